heater_array: RTL
=================

# heater_array

Parametrised multi-channel power-burn block: CHANNELS independent lanes, each with an LFSR data source, a DEPTH-stage register pipeline and a self-synchronising checker. Power is controlled by a duty-cycle throttle and a soft-start ramp that enables channels one at a time to limit di/dt. Error injection supports bench and in-system self-test. The block sits at top level beside the existing single-channel heaters and is driven from the board control registers.

## Interface
- CHANNELS, 8: number of lanes, 1..64.
- WIDTH, 64: data bits per lane, multiple of 32, built from WIDTH/32 32-bit LFSR sub-lanes.
- DEPTH, 16: pipeline register stages per lane, at least 1.
- RAMP_CYCLES, 1024: cycles between successive channel turn-ons, at least 1.
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high; clears all state including sticky errors.
- enable  in  1  run request; low stops all lanes and re-arms generators and checkers.
- level  in  8  throttle; each lane advances on level/256 of cycles.
- chan_mask  in  CHANNELS  per-lane permit; 0 parks the lane with data held.
- err_clear  in  1  clears the sticky errors and err_count.
- inject_err  in  1  single-cycle pulse; corrupts one word on lane 0.
- active_chans  out  7  number of lanes the ramp has released, 0..CHANNELS.
- err_chan  out  CHANNELS  sticky per-lane error.
- error  out  1  OR of err_chan.
- err_count  out  16  saturating count of mismatch events.

## Operation
- **LFSR sub-lane step.** next = {cur[30:0], cur[31]^cur[21]^cur[1]^cur[0]}.
  - Seed of global sub-lane index s (lane*WIDTH/32 + j) is 32'hFFFF_FFFF ^ s.
  - A lane word is the concatenation of its sub-lanes, with j=0 in the LSBs.
- **Ramp.** ramp_cnt counts cycles while enable=1.
  - When ramp_cnt reaches RAMP_CYCLES-1 and active_chans<CHANNELS, active_chans increments and ramp_cnt wraps to 0.
  - active_chans saturates at CHANNELS.
  - enable=0 forces active_chans=0 and ramp_cnt=0.
- **Throttle.** An 8-bit accumulator acc updates every cycle with acc <= acc+level (mod 256).
  - adv = carry out of that addition.
  - level=0 gives no advances. level=128 advances on alternate cycles.
- **Lane run condition.** run[k] = enable & chan_mask[k] & (k < active_chans) & adv.
  - When run[k]=1, the lane LFSR steps and {valid=1, word} enters stage 0. The word entered is the pre-step state, so the seed is the first word.
  - Otherwise valid=0 enters and the data registers hold their value, giving no toggling.
  - All stages shift every cycle.
- **Checker (per lane).** Acts on the final stage only when valid=1.
  - Unarmed: load pred <= step(word) and become armed. No error is raised.
  - Armed: mismatch if word != pred. Then pred <= step(word), so the checker resynchronises after one bad word.
- **Error injection.** inject_err XORs bit 0 of the next lane-0 word entering stage 0.
  - It is held pending until lane 0 runs.
  - A pulse is expected to produce exactly 2 mismatches: the corrupted word, and the following word predicted from it.
- **Error reporting.**
  - A mismatch sets err_chan[k].
  - err_count += popcount(mismatches this cycle), saturating at 16'hFFFF.
  - err_clear zeroes err_chan and err_count. A mismatch in the same cycle as err_clear is discarded.
- **enable=0.** Synchronously:
  - reload the LFSRs to their seeds;
  - clear pipeline valids;
  - unarm the checkers;
  - clear the pending injection.
  
  err_chan and err_count are retained.
- **Parked lanes.** A lane parked by chan_mask or the throttle keeps its LFSR, pipeline and checker state, so resuming causes no error.

## Timing
- **Reset values.** Every output is 0 after reset: active_chans, err_chan, error, err_count. Also acc=0, pipelines invalid, checkers unarmed.
- **Ramp start.** active_chans first becomes 1 at RAMP_CYCLES cycles after the enable rising edge.
- **Data latency.** A word generated in cycle t reaches the checker input in cycle t+DEPTH.
- **Error latency.**
  - err_chan and err_count update in cycle t+DEPTH+1.
  - error is registered from err_chan and updates in cycle t+DEPTH+2.
- **Register-level effects.** enable, err_clear and chan_mask take effect on the next clock edge.
- **Reset priority.** reset has priority over all inputs. A reset mid-run behaves as a fresh start.

## Test plan
- **Power-up.** Apply reset, then enable=1, level=255, chan_mask all 1s, CHANNELS=8, RAMP_CYCLES=16 -> active_chans steps 1..8 at cycles 16, 32, ... 128 after enable, then holds at 8; error=0 and err_count=0 over 10k cycles.
- **Throttle.** Run with level=64 -> each lane's LFSR advances exactly 256 times in 1024 cycles. With level=0 -> stage-0 data is constant and error stays 0.
- **Injection.** Pulse inject_err once with level=255 -> err_chan=8'h01, err_count=2, error=1; the remaining lanes are clean. Then pulse err_clear -> all error outputs return to 0 and stay 0.
- **Masking.** Toggle chan_mask[3] every 37 cycles while running -> no errors on any lane.
- **Stop/restart.** Drop enable for 5 cycles mid-run, then raise it -> active_chans=0 within 1 cycle, ramp restarts from 0, no errors. Also run err_count saturation with a forced mismatch every cycle -> err_count holds at 16'hFFFF.
- **Reset during injection.** Assert reset in the same cycle as inject_err -> no error results after re-enable.

Source files
------------

// File: rtl/heater_array_if.sv
// Control/status bundle between the board control registers and heater_array.
interface heater_array_if #(
  parameter int CHANNELS = 8
);
  logic                enable;
  logic [7:0]          level;
  logic [CHANNELS-1:0] chan_mask;
  logic                err_clear;
  logic                inject_err;
  logic [6:0]          active_chans;
  logic [CHANNELS-1:0] err_chan;
  logic                error;
  logic [15:0]         err_count;

  modport master (
    output enable, level, chan_mask, err_clear, inject_err,
    input  active_chans, err_chan, error, err_count
  );

  modport slave (
    input  enable, level, chan_mask, err_clear, inject_err,
    output active_chans, err_chan, error, err_count
  );
endinterface

// File: rtl/heater_array.sv
// Multi-lane power-burn block: per-lane LFSR source, DEPTH-stage pipeline and
// self-synchronising checker, with a duty-cycle throttle and a soft-start ramp.
module heater_array #(
  parameter int CHANNELS    = 8,
  parameter int WIDTH       = 64,
  parameter int DEPTH       = 16,
  parameter int RAMP_CYCLES = 1024
) (
  input logic          clk,
  input logic          reset,
  heater_array_if.slave bus
);

  localparam int SUBS = WIDTH / 32;
  localparam int RW   = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_CYCLES - 1);

  function automatic logic [31:0] lfsr_step32(input logic [31:0] cur);
    return {cur[30:0], cur[31] ^ cur[21] ^ cur[1] ^ cur[0]};
  endfunction

  function automatic logic [WIDTH-1:0] lane_step(input logic [WIDTH-1:0] cur);
    logic [WIDTH-1:0] nxt;
    nxt = '0;
    for (int j = 0; j < SUBS; j++) begin
      nxt[j*32 +: 32] = lfsr_step32(cur[j*32 +: 32]);
    end
    return nxt;
  endfunction

  function automatic logic [WIDTH-1:0] lane_seed(input int lane);
    logic [WIDTH-1:0] seed;
    seed = '0;
    for (int j = 0; j < SUBS; j++) begin
      seed[j*32 +: 32] = 32'hFFFF_FFFF ^ 32'(lane * SUBS + j);
    end
    return seed;
  endfunction

  function automatic logic [6:0] popcount(input logic [CHANNELS-1:0] v);
    logic [6:0] cnt;
    cnt = 7'd0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt = cnt + 7'(v[i]);
    end
    return cnt;
  endfunction

  logic [RW-1:0]                   ramp_cnt_r;
  logic [6:0]                      active_r;
  logic [7:0]                      acc_r;
  logic [8:0]                      acc_sum_s;
  logic                            adv_s;
  logic [CHANNELS-1:0]             run_s;
  logic                            inj_pend_r;
  logic                            inj_now_s;
  logic [CHANNELS-1:0][WIDTH-1:0]  lfsr_r;
  logic [WIDTH-1:0]                entry_s [CHANNELS];
  logic [DEPTH-1:0]                pv_r    [CHANNELS];
  logic [WIDTH-1:0]                pd_r    [CHANNELS][DEPTH];
  logic [CHANNELS-1:0]             armed_r;
  logic [WIDTH-1:0]                pred_r  [CHANNELS];
  logic [CHANNELS-1:0]             mismatch_s;
  logic [16:0]                     cnt_sum_s;
  logic [CHANNELS-1:0]             err_chan_r;
  logic                            error_r;
  logic [15:0]                     err_count_r;

  // Soft-start ramp: release one more lane every RAMP_CYCLES cycles
  always_ff @(posedge clk) begin
    if (reset || !bus.enable) begin
      ramp_cnt_r <= '0;
      active_r   <= 7'd0;
    end else if (ramp_cnt_r == RAMP_LAST) begin
      ramp_cnt_r <= '0;
      if (active_r < 7'(CHANNELS)) begin
        active_r <= active_r + 7'd1;
      end
    end else begin
      ramp_cnt_r <= ramp_cnt_r + RW'(1);
    end
  end

  assign acc_sum_s = {1'b0, acc_r} + {1'b0, bus.level};
  assign adv_s     = acc_sum_s[8];

  // Throttle accumulator; its carry is the advance strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r <= 8'd0;
    end else begin
      acc_r <= acc_sum_s[7:0];
    end
  end

  // Per-lane run strobes and the stage-0 word (with lane-0 injection)
  always_comb begin
    run_s     = '0;
    inj_now_s = inj_pend_r | bus.inject_err;
    for (int k = 0; k < CHANNELS; k++) begin
      run_s[k]   = bus.enable & bus.chan_mask[k] & (k < int'(active_r)) & adv_s;
      entry_s[k] = lfsr_r[k];
    end
    entry_s[0][0] = lfsr_r[0][0] ^ inj_now_s;
  end

  // An injection request waits until lane 0 actually produces a word
  always_ff @(posedge clk) begin
    if (reset || !bus.enable) begin
      inj_pend_r <= 1'b0;
    end else begin
      inj_pend_r <= inj_now_s & ~run_s[0];
    end
  end

  // Lane generators: restart from seed whenever the block is stopped
  always_ff @(posedge clk) begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (reset || !bus.enable) begin
        lfsr_r[k] <= lane_seed(k);
      end else if (run_s[k]) begin
        lfsr_r[k] <= lane_step(lfsr_r[k]);
      end
    end
  end

  // Pipeline: valids always shift; stage-0 data holds when the lane is idle
  always_ff @(posedge clk) begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (reset || !bus.enable) begin
        pv_r[k] <= '0;
      end else begin
        pv_r[k][0] <= run_s[k];
        for (int i = 1; i < DEPTH; i++) begin
          pv_r[k][i] <= pv_r[k][i-1];
        end
      end
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) begin
          pd_r[k][i] <= '0;
        end
      end else begin
        if (run_s[k]) begin
          pd_r[k][0] <= entry_s[k];
        end
        for (int i = 1; i < DEPTH; i++) begin
          pd_r[k][i] <= pd_r[k][i-1];
        end
      end
    end
  end

  // Mismatch detect on the last stage of each armed lane
  always_comb begin
    mismatch_s = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      mismatch_s[k] = bus.enable & pv_r[k][DEPTH-1] & armed_r[k]
                      & (pd_r[k][DEPTH-1] != pred_r[k]);
    end
  end

  // Checkers predict from the word just seen, so one bad word cannot cascade
  always_ff @(posedge clk) begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (reset) begin
        armed_r[k] <= 1'b0;
        pred_r[k]  <= '0;
      end else if (!bus.enable) begin
        armed_r[k] <= 1'b0;
      end else if (pv_r[k][DEPTH-1]) begin
        armed_r[k] <= 1'b1;
        pred_r[k]  <= lane_step(pd_r[k][DEPTH-1]);
      end
    end
  end

  assign cnt_sum_s = {1'b0, err_count_r} + 17'(popcount(mismatch_s));

  // Sticky error state; clear wins over a same-cycle mismatch
  always_ff @(posedge clk) begin
    if (reset || bus.err_clear) begin
      err_chan_r  <= '0;
      err_count_r <= 16'd0;
    end else begin
      err_chan_r  <= err_chan_r | mismatch_s;
      err_count_r <= cnt_sum_s[16] ? 16'hFFFF : cnt_sum_s[15:0];
    end
  end

  // Summary flag, one register behind err_chan
  always_ff @(posedge clk) begin
    if (reset) begin
      error_r <= 1'b0;
    end else begin
      error_r <= |err_chan_r;
    end
  end

  assign bus.active_chans = active_r;
  assign bus.err_chan     = err_chan_r;
  assign bus.error        = error_r;
  assign bus.err_count    = err_count_r;

endmodule
